pearray_feeder: RTL and testbench

- Upstream feeder for the 8-lane PE array.
- Accepts a serial stream of 16-bit words over valid/ready and unpacks each tile into three parts: one FIFO seed word, one bias row of PENUM words, and one or more activation rows of PENUM words.
- Drives the array's per-lane operand bus, per-lane bias bus and infifo input from registers.
- Each activation row is presented once, as a single valid/ready transfer.

---
 rtl/pearray_pkg.sv | 16 +
 rtl/pearray_row_packer.sv | 56 +++++
 rtl/pearray_feeder.sv | 166 ++++++++++++++++
 tb/tb_pearray_feeder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pearray_pkg.sv
// Shared types and default sizes for the PE-array feeder.
// Lanes are packed lane k at [k*DATA_WIDTH +: DATA_WIDTH].
package pearray_pkg;
  localparam int PENUM      = 8;
  localparam int DATA_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef word_t row_t [PENUM];

  typedef enum logic [1:0] {
    IDLE,
    BIAS,
    ACT,
    TAIL
  } feeder_state_e;
endpackage

// File: rtl/pearray_row_packer.sv
// Collects one row of PENUM words lane by lane and presents the completed
// row (zero-padded past the current lane) together with a full strobe.
module pearray_row_packer #(
  parameter int PENUM      = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic                        last,
  input  logic [DATA_WIDTH-1:0]       data,
  output logic                        lane_end,
  output logic                        full,
  output logic                        pad,
  output logic [PENUM*DATA_WIDTH-1:0] row
);
  localparam int LANE_W = (PENUM > 1) ? $clog2(PENUM) : 1;

  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DATA_WIDTH-1:0] shadow_q [PENUM];

  assign lane_end = (lane_q == LANE_W'(PENUM - 1));
  assign full     = wr_en && (lane_end || last);
  assign pad      = wr_en && last && !lane_end;

  always_comb begin
    lane_d = lane_q;
    if (full) begin
      lane_d = '0;
    end else if (wr_en) begin
      lane_d = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      for (int k = 0; k < PENUM; k++) shadow_q[k] <= '0;
    end else begin
      lane_q <= lane_d;
      if (wr_en) shadow_q[lane_q] <= data;
    end
  end

  // Lanes beyond the current one belong to an older row, so they read as zero.
  always_comb begin
    row = '0;
    for (int k = 0; k < PENUM; k++) begin
      if (LANE_W'(k) < lane_q) begin
        row[k*DATA_WIDTH +: DATA_WIDTH] = shadow_q[k];
      end else if (LANE_W'(k) == lane_q) begin
        row[k*DATA_WIDTH +: DATA_WIDTH] = data;
      end
    end
  end
endmodule

// File: rtl/pearray_feeder.sv
// Unpacks a serial word stream into seed / bias row / activation rows for
// the PE array. Optional issued-row counter enabled by FEEDER_STATS_EN.
//
// state | meaning
// IDLE  | waiting for the tile seed word (goes to infifo)
// BIAS  | collecting the bias row
// ACT   | collecting activation rows, each issued over arr_valid/arr_ready
// TAIL  | last row issued, waiting for it to be consumed
module pearray_feeder #(
  parameter int PENUM      = pearray_pkg::PENUM,
  parameter int DATA_WIDTH = pearray_pkg::DATA_WIDTH
`ifdef FEEDER_STATS_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_last,
  output logic                        arr_valid,
  input  logic                        arr_ready,
  output logic [PENUM*DATA_WIDTH-1:0] iarray,
  output logic [PENUM*DATA_WIDTH-1:0] ibiasarray,
  output logic [DATA_WIDTH-1:0]       infifo,
  output logic                        tile_done,
  output logic                        err
`ifdef FEEDER_STATS_EN
  , output logic [CNT_W-1:0]          row_count
`endif
);
  import pearray_pkg::*;

  feeder_state_e state_q, state_d;

  logic [PENUM*DATA_WIDTH-1:0] iarray_q, ibias_q;
  logic [DATA_WIDTH-1:0]       infifo_q;
  logic                        arr_valid_q, arr_valid_d;
  logic                        tile_done_q;
  logic                        last_q, last_d;
  logic                        err_q, err_d;

  logic accept, consume;
  logic bias_wr, act_wr;
  logic bias_end, bias_full, bias_pad;
  logic act_end, act_full, act_pad;
  logic [PENUM*DATA_WIDTH-1:0] bias_row, act_row;
  logic unused_bias;

  assign accept  = s_valid && s_ready;
  assign consume = arr_valid_q && arr_ready;
  assign bias_wr = accept && (state_q == BIAS);
  assign act_wr  = accept && (state_q == ACT);

  pearray_row_packer #(.PENUM(PENUM), .DATA_WIDTH(DATA_WIDTH)) u_bias_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bias_wr),
    .last     (1'b0),
    .data     (s_data),
    .lane_end (bias_end),
    .full     (bias_full),
    .pad      (bias_pad),
    .row      (bias_row)
  );

  pearray_row_packer #(.PENUM(PENUM), .DATA_WIDTH(DATA_WIDTH)) u_act_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (act_wr),
    .last     (s_last),
    .data     (s_data),
    .lane_end (act_end),
    .full     (act_full),
    .pad      (act_pad),
    .row      (act_row)
  );

  assign unused_bias = bias_end ^ bias_pad;

  // A word that would complete a row (full lane or early last) must wait
  // while the previous row is still unconsumed.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      IDLE:    s_ready = 1'b1;
      BIAS:    s_ready = !arr_valid_q;
      ACT:     s_ready = !((act_end || s_last) && arr_valid_q && !arr_ready);
      default: s_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BIAS;
      BIAS:    if (bias_full) state_d = ACT;
      ACT:     if (act_full && s_last) state_d = TAIL;
      TAIL:    if (consume) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arr_valid_d = arr_valid_q;
    if (act_full) begin
      arr_valid_d = 1'b1;
    end else if (consume) begin
      arr_valid_d = 1'b0;
    end

    last_d = last_q;
    if (act_full && s_last) begin
      last_d = 1'b1;
    end else if (consume) begin
      last_d = 1'b0;
    end

    err_d = err_q || act_pad || bias_pad ||
            (accept && s_last && (state_q == IDLE || state_q == BIAS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iarray_q    <= '0;
      ibias_q     <= '0;
      infifo_q    <= '0;
      arr_valid_q <= 1'b0;
      tile_done_q <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      arr_valid_q <= arr_valid_d;
      last_q      <= last_d;
      err_q       <= err_d;
      tile_done_q <= consume && last_q;
      if (accept && state_q == IDLE) infifo_q <= s_data;
      if (bias_full) ibias_q <= bias_row;
      if (act_full) iarray_q <= act_row;
    end
  end

  assign iarray     = iarray_q;
  assign ibiasarray = ibias_q;
  assign infifo     = infifo_q;
  assign arr_valid  = arr_valid_q;
  assign tile_done  = tile_done_q;
  assign err        = err_q;

`ifdef FEEDER_STATS_EN
  logic [CNT_W-1:0] row_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_count_q <= '0;
    end else if (consume && (row_count_q != '1)) begin
      row_count_q <= row_count_q + 1'b1;
    end
  end

  assign row_count = row_count_q;
`endif
endmodule

// File: tb/tb_pearray_feeder.sv
// Scoreboard bench for pearray_feeder: tiles are turned into expected rows by
// a word-list model; a monitor pops and compares on every consumed row.
module tb_pearray_feeder;
  localparam int P = 8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [W-1:0]   s_data = '0;
  logic           s_last = 1'b0;
  logic           arr_valid;
  logic           arr_ready = 1'b1;
  logic [P*W-1:0] iarray;
  logic [P*W-1:0] ibiasarray;
  logic [W-1:0]   infifo;
  logic           tile_done;
  logic           err;
`ifdef FEEDER_STATS_EN
  logic [15:0]    row_count;
`endif

  always #5 clk = ~clk;

  pearray_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .arr_valid  (arr_valid),
    .arr_ready  (arr_ready),
    .iarray     (iarray),
    .ibiasarray (ibiasarray),
    .infifo     (infifo),
    .tile_done  (tile_done),
    .err        (err)
`ifdef FEEDER_STATS_EN
    , .row_count(row_count)
`endif
  );

  typedef struct {
    logic [P*W-1:0] arr;
    logic [P*W-1:0] bias;
    logic [W-1:0]   fifo;
    bit             last;
    bit             err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  bit   model_err = 1'b0;
  int   model_rows = 0;
  int   ready_mode = 0;
  bit   done_pend = 1'b0;
  int   cyc = 0;

  task automatic check(input string name, input logic [P*W-1:0] got, input logic [P*W-1:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       arr_ready = 1'b1;
      1:       arr_ready = ($urandom_range(0, 3) != 0);
      default: arr_ready = 1'b0;
    endcase
  end

  // Monitor: every consumed row is popped and compared; tile_done must pulse
  // exactly in the cycle after the tile's last row is consumed.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      done_pend = 1'b0;
    end else begin
      check("tile_done", tile_done, done_pend);
      done_pend = 1'b0;
      if (arr_valid && arr_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_row", 1, 0);
        end else begin
          e = sb.pop_front();
          check("iarray", iarray, e.arr);
          check("ibiasarray", ibiasarray, e.bias);
          check("infifo", infifo, e.fifo);
          check("err", err, e.err);
          done_pend = e.last;
          model_rows++;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit last, input int maxgap);
    bit acc;
    if (maxgap > 0) repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      if (i > 300) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Model: a tile is a seed, a bias row and a flat word list; rows are the
  // list cut into groups of P, the final group zero-filled.
  task automatic model_push(input logic [W-1:0] seed, input logic [W-1:0] bias[P],
                            input logic [W-1:0] act[$], input int stray);
    logic [P*W-1:0] bp, rp;
    int n, nrows;
    exp_t e;
    bp = '0;
    for (int k = 0; k < P; k++) bp[k*W +: W] = bias[k];
    if (stray >= 0) model_err = 1'b1;
    n = act.size();
    nrows = (n + P - 1) / P;
    for (int r = 0; r < nrows; r++) begin
      rp = '0;
      for (int k = 0; k < P; k++) if (r*P + k < n) rp[k*W +: W] = act[r*P + k];
      if (r == nrows - 1 && (n % P) != 0) model_err = 1'b1;
      e.arr = rp; e.bias = bp; e.fifo = seed;
      e.last = (r == nrows - 1); e.err = model_err;
      sb.push_back(e);
    end
  endtask

  task automatic run_tile(input logic [W-1:0] seed, input logic [W-1:0] bias[P],
                          input logic [W-1:0] act[$], input int stray, input int maxgap);
    model_push(seed, bias, act, stray);
    send(seed, stray == 0, maxgap);
    for (int k = 0; k < P; k++) send(bias[k], stray == k + 1, maxgap);
    for (int i = 0; i < act.size(); i++) send(act[i], i == act.size() - 1, maxgap);
  endtask

  task automatic drain();
    int i = 0;
    while ((sb.size() != 0 || arr_valid) && i < 500) begin
      @(posedge clk); #1; i++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   b[P];
    logic [W-1:0]   a[$];
    logic [P*W-1:0] r1, r2;
    int c0;

    #12;
    check("rst_iarray", iarray, 0);
    check("rst_ibias", ibiasarray, 0);
    check("rst_infifo", infifo, 0);
    check("rst_arr_valid", arr_valid, 0);
    check("rst_tile_done", tile_done, 0);
    check("rst_err", err, 0);
    check("rst_s_ready", s_ready, 1);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // basic tile
    for (int k = 0; k < P; k++) b[k] = W'(16'h0010 + k);
    a.delete();
    for (int k = 0; k < P; k++) a.push_back(W'(k + 1));
    run_tile(16'h00AA, b, a, -1, 0);
    check("basic_latency", arr_valid, 1);
    @(posedge clk); #1;
    check("basic_one_cycle", arr_valid, 0);
    check("basic_tile_done", tile_done, 1);
    check("basic_infifo", infifo, 16'h00AA);
    check("basic_ibias", ibiasarray, 128'h0017_0016_0015_0014_0013_0012_0011_0010);
    drain();

    // streaming: 41 words must take exactly 41 edges
    for (int k = 0; k < P; k++) b[k] = W'($urandom);
    a.delete();
    repeat (4*P) a.push_back(W'($urandom));
    c0 = cyc;
    run_tile(W'($urandom), b, a, -1, 0);
    check("stream_cycles", cyc - c0, 1 + P + 4*P);
    drain();
`ifdef FEEDER_STATS_EN
    check("stream_row_count", row_count, 5);
`endif

    // backpressure across row 1 -> row 2
    for (int k = 0; k < P; k++) b[k] = W'($urandom);
    a.delete();
    repeat (2*P) a.push_back(W'($urandom));
    r1 = '0; r2 = '0;
    for (int k = 0; k < P; k++) begin
      r1[k*W +: W] = a[k];
      r2[k*W +: W] = a[P + k];
    end
    model_push(16'h0BEE, b, a, -1);
    ready_mode = 2;
    send(16'h0BEE, 0, 0);
    for (int k = 0; k < P; k++) send(b[k], 0, 0);
    for (int i = 0; i < 2*P - 1; i++) send(a[i], 0, 0);
    s_valid = 1'b1; s_data = a[2*P-1]; s_last = 1'b1;
    @(negedge clk);
    check("bp_s_ready_low", s_ready, 0);
    check("bp_iarray_row1", iarray, r1);
    repeat (19) @(negedge clk);
    check("bp_iarray_hold", iarray, r1);
    check("bp_arr_valid_hold", arr_valid, 1);
    ready_mode = 0;
    send(a[2*P-1], 1, 0);
    check("bp_row2_valid", arr_valid, 1);
    check("bp_row2_data", iarray, r2);
    drain();

    // randomized tiles with gaps, random backpressure, short rows, stray lasts
    ready_mode = 1;
    repeat (25) begin
      int n, stray;
      for (int k = 0; k < P; k++) b[k] = W'($urandom);
      n = $urandom_range(1, 4*P);
      a.delete();
      repeat (n) a.push_back(W'($urandom));
      stray = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, P)) : -1;
      run_tile(W'($urandom), b, a, stray, 2);
    end
    ready_mode = 0;
    drain();

    // reset during BIAS lane 4
    for (int k = 0; k < P; k++) b[k] = W'($urandom);
    send(16'h5A5A, 0, 0);
    for (int k = 0; k < 4; k++) send(b[k], 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_iarray", iarray, 0);
    check("mid_rst_ibias", ibiasarray, 0);
    check("mid_rst_infifo", infifo, 0);
    check("mid_rst_arr_valid", arr_valid, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_s_ready", s_ready, 1);
    model_err = 1'b0;
    model_rows = 0;
    #7 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < P; k++) b[k] = W'($urandom);
    a.delete();
    repeat (P) a.push_back(W'($urandom));
    run_tile(16'h1234, b, a, -1, 0);
    drain();
    check("post_rst_err", err, 0);

    // stray last on a bias word
    for (int k = 0; k < P; k++) b[k] = W'(16'h0100 + k);
    a.delete();
    repeat (P) a.push_back(W'($urandom));
    run_tile(16'h0077, b, a, 3, 0);
    drain();
    check("stray_ibias", ibiasarray, 128'h0107_0106_0105_0104_0103_0102_0101_0100);

    // short row
    for (int k = 0; k < P; k++) b[k] = W'($urandom);
    a.delete();
    a.push_back(16'd5); a.push_back(16'd6); a.push_back(16'd7);
    run_tile(16'h0033, b, a, -1, 0);
    drain();
    check("short_iarray", iarray, 128'h0000_0000_0000_0000_0000_0007_0006_0005);
    check("err_sticky", err, 1);
`ifdef FEEDER_STATS_EN
    check("row_count_final", row_count, model_rows);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
